// File: rtl/a2d_pkg.sv
// Shared types, channel map and helpers for the A2D round-robin scheduler.
//   a2d_state_t : scheduler FSM state encoding
//   CH_*        : ADC128S channel numbers, one per measured quantity
//   mk_cmd      : builds the 16-bit SPI command word for a channel
//   ptr2chnl    : maps the round-robin pointer (0..3) onto its channel
package a2d_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TX1,
        WT1,
        GAP,
        TX2,
        WT2,
        CAP
    } a2d_state_t;

    localparam logic [2:0] CH_LFT   = 3'd0;
    localparam logic [2:0] CH_RGHT  = 3'd4;
    localparam logic [2:0] CH_STEER = 3'd5;
    localparam logic [2:0] CH_BATT  = 3'd6;

    function automatic logic [15:0] mk_cmd(input logic [2:0] chnl);
        return {2'b00, chnl, 11'h000};
    endfunction

    function automatic logic [2:0] ptr2chnl(input logic [1:0] ptr);
        logic [2:0] chnl;
        case (ptr)
            2'd0:    chnl = CH_LFT;
            2'd1:    chnl = CH_RGHT;
            2'd2:    chnl = CH_STEER;
            default: chnl = CH_BATT;
        endcase
        return chnl;
    endfunction

endpackage

// File: rtl/a2d_rr_sched_if.sv
// SPI-master handshake between the scheduler and the SPI master.
//   wrt     : 1-clk launch pulse for a 16-bit transaction
//   cmd     : command word, held for the whole transaction
//   done    : 1-clk completion pulse from the SPI master
//   rd_data : word shifted in, valid while done=1
// The scheduler is the master modport; the SPI engine is the slave modport.
interface a2d_rr_sched_if;

    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;

    modport master (
        output wrt,
        output cmd,
        input  done,
        input  rd_data
    );

    modport slave (
        input  wrt,
        input  cmd,
        output done,
        output rd_data
    );

endinterface

// File: rtl/a2d_gap_cnt.sv
// Loadable down-counter that times the idle gap between the two SPI
// transactions of a conversion.
//   clk, rst_n : clock, synchronous active-low reset
//   ld         : load ld_val (takes priority over en)
//   ld_val     : value loaded; the count then runs ld_val+1 enabled clocks
//   en         : decrement while non-zero
//   tc         : terminal count, high when the counter is zero
module a2d_gap_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (ld) begin
            cnt_q <= ld_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/a2d_rr_sched.sv
// Round-robin conversion scheduler for the shared ADC128S SPI link.
// Each nxt strobe converts the next channel (left load cell, right load
// cell, steering pot, battery) using two SPI transactions; the first
// read is ADC pipeline junk, the second carries the conversion result.
//   clk, rst_n  : clock, synchronous active-low reset
//   nxt         : start-next-conversion strobe
//   spi         : SPI master handshake (wrt/cmd out, done/rd_data in)
//   lft_ld, rght_ld, steer_pot, batt : latest 12-bit results
//   rslt_vld    : 1-clk pulse when a result register updates
//   rslt_idx    : which result updated (0 lft, 1 rght, 2 steer, 3 batt)
//   ovr         : sticky, a nxt was dropped while busy with one pending
//
// state | meaning
// IDLE  | waiting for nxt or a pending request
// TX1   | wrt pulse for the dummy transaction
// WT1   | waiting for done of the dummy transaction (data discarded)
// GAP   | idle clocks before the second transaction
// TX2   | wrt pulse for the result transaction, same cmd
// WT2   | waiting for done; result captured on done
// CAP   | rslt_vld pulse, advance the round-robin pointer
module a2d_rr_sched
    import a2d_pkg::*;
#(
    parameter int unsigned GAP_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  nxt,
    a2d_rr_sched_if.master        spi,
    output logic [11:0]           lft_ld,
    output logic [11:0]           rght_ld,
    output logic [11:0]           steer_pot,
    output logic [11:0]           batt,
    output logic                  rslt_vld,
    output logic [1:0]            rslt_idx,
    output logic                  ovr
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    a2d_state_t  state_q;
    logic [1:0]  ptr_q;
    logic        pend_q;
    logic        ovr_q;
    logic        wrt_q;
    logic [15:0] cmd_q;
    logic        vld_q;
    logic [1:0]  idx_q;
    logic [11:0] rslt_q [4];

    logic gap_ld;
    logic gap_en;
    logic gap_tc;

    // Loading GAP_CYC-1 on the WT1 done makes GAP last exactly GAP_CYC clocks.
    assign gap_ld = (state_q == WT1) && spi.done;
    assign gap_en = (state_q == GAP);

    a2d_gap_cnt #(
        .W (GAP_W)
    ) u_gap_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld     (gap_ld),
        .ld_val (GAP_W'(GAP_CYC - 1)),
        .en     (gap_en),
        .tc     (gap_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            wrt_q   <= 1'b0;
            cmd_q   <= 16'h0000;
            vld_q   <= 1'b0;
            idx_q   <= 2'd0;
            rslt_q  <= '{default: '0};
        end else begin
            wrt_q <= 1'b0;
            vld_q <= 1'b0;

            // One request can queue behind the running conversion; a further
            // one is dropped and flagged.
            if (nxt && (state_q != IDLE)) begin
                if (!pend_q) begin
                    pend_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (nxt || pend_q) begin
                        state_q <= TX1;
                        pend_q  <= 1'b0;
                        wrt_q   <= 1'b1;
                        cmd_q   <= mk_cmd(ptr2chnl(ptr_q));
                    end
                end
                TX1: begin
                    state_q <= WT1;
                end
                WT1: begin
                    if (spi.done) begin
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (gap_tc) begin
                        state_q <= TX2;
                        wrt_q   <= 1'b1;
                    end
                end
                TX2: begin
                    state_q <= WT2;
                end
                WT2: begin
                    if (spi.done) begin
                        rslt_q[ptr_q] <= spi.rd_data[11:0];
                        vld_q         <= 1'b1;
                        idx_q         <= ptr_q;
                        state_q       <= CAP;
                    end
                end
                CAP: begin
                    ptr_q   <= ptr_q + 2'd1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign spi.wrt   = wrt_q;
    assign spi.cmd   = cmd_q;
    assign lft_ld    = rslt_q[0];
    assign rght_ld   = rslt_q[1];
    assign steer_pot = rslt_q[2];
    assign batt      = rslt_q[3];
    assign rslt_vld  = vld_q;
    assign rslt_idx  = idx_q;
    assign ovr       = ovr_q;

endmodule

// File: tb/tb_a2d_rr_sched.sv
// Bench for a2d_rr_sched: a behavioural SPI/ADC responder plus a
// request-level reference model (busy / one pending / overrun).
module tb_a2d_rr_sched;

    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        nxt;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;
    logic        rslt_vld;
    logic [1:0]  rslt_idx;
    logic        ovr;

    a2d_rr_sched_if spi_if();

    a2d_rr_sched #(.GAP_CYC(GAP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .nxt       (nxt),
        .spi       (spi_if),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .steer_pot (steer_pot),
        .batt      (batt),
        .rslt_vld  (rslt_vld),
        .rslt_idx  (rslt_idx),
        .ovr       (ovr)
    );

    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_cmd(input logic [1:0] p);
        case (p)
            2'd0:    return 16'h0000;
            2'd1:    return 16'h2000;
            2'd2:    return 16'h2800;
            default: return 16'h3000;
        endcase
    endfunction

    // ADC values indexed by result slot (lft, rght, steer, batt)
    logic [11:0] adc [4];

    // ---------------- SPI master + ADC responder ----------------
    int stray_req = 0;
    int stray_ack = 0;

    initial begin
        logic [2:0]  prev_ch;
        logic [2:0]  ch;
        logic [11:0] val;
        int          lat;
        prev_ch = 3'd7;
        spi_if.done    = 1'b0;
        spi_if.rd_data = 16'h0000;
        forever begin
            @(negedge clk);
            if (stray_req != stray_ack) begin
                @(posedge clk);
                #1 spi_if.done = 1'b1;
                spi_if.rd_data = 16'($urandom);
                @(posedge clk);
                #1 spi_if.done = 1'b0;
                stray_ack++;
            end else if (spi_if.wrt) begin
                ch  = spi_if.cmd[13:11];
                lat = $urandom_range(3, 12);
                // the ADC answers with the channel addressed by the previous command
                case (prev_ch)
                    3'd0:    val = adc[0];
                    3'd4:    val = adc[1];
                    3'd5:    val = adc[2];
                    3'd6:    val = adc[3];
                    default: val = 12'($urandom);
                endcase
                prev_ch = ch;
                repeat (lat) @(posedge clk);
                #1 spi_if.done = 1'b1;
                spi_if.rd_data = {4'($urandom), val};
                @(posedge clk);
                #1 spi_if.done = 1'b0;
            end
        end
    end

    // ---------------- reference model and protocol monitor ----------------
    logic        mon_en = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_pend = 1'b0;
    logic        m_ovr  = 1'b0;
    logic [1:0]  m_ptr  = 2'd0;
    logic [11:0] m_res [4] = '{default: 12'h000};
    int          nwrt = 0;
    int          ndone = 0;
    int          conv_cnt = 0;
    int          cyc = 0;
    int          last_done = -100;
    int          start_cyc = 0;
    logic [15:0] cmd_hold = 16'h0000;

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            chk("ovr", 32'(ovr), 32'(m_ovr));
            if (!rst_n) begin
                m_busy = 1'b0;
                m_pend = 1'b0;
                m_ovr  = 1'b0;
                m_ptr  = 2'd0;
                for (int i = 0; i < 4; i++) m_res[i] = 12'h000;
                nwrt  = 0;
                ndone = 0;
            end else begin
                if (spi_if.wrt) begin
                    chk("wrt_when_busy", 32'(m_busy), 32'd1);
                    chk("cmd", 32'(spi_if.cmd), 32'(exp_cmd(m_ptr)));
                    if (nwrt == 0) chk("nxt_to_wrt", 32'(cyc - start_cyc), 32'd1);
                    else           chk("gap", 32'(cyc - last_done), 32'(GAP + 1));
                    nwrt++;
                    cmd_hold = spi_if.cmd;
                end else if (m_busy && nwrt > 0) begin
                    chk("cmd_hold", 32'(spi_if.cmd), 32'(cmd_hold));
                end
                if (spi_if.done && m_busy) begin
                    last_done = cyc;
                    ndone++;
                end
                if (rslt_vld) begin
                    chk("vld_when_busy", 32'(m_busy), 32'd1);
                    chk("rslt_idx", 32'(rslt_idx), 32'(m_ptr));
                    chk("wrt_per_conv", 32'(nwrt), 32'd2);
                    m_res[m_ptr] = adc[m_ptr];
                    m_ptr++;
                    conv_cnt++;
                end
                chk("lft_ld",    32'(lft_ld),    32'(m_res[0]));
                chk("rght_ld",   32'(rght_ld),   32'(m_res[1]));
                chk("steer_pot", 32'(steer_pot), 32'(m_res[2]));
                chk("batt",      32'(batt),      32'(m_res[3]));
                if (!m_busy) begin
                    if (nxt || m_pend) begin
                        m_busy    = 1'b1;
                        m_pend    = 1'b0;
                        nwrt      = 0;
                        ndone     = 0;
                        start_cyc = cyc;
                    end
                end else begin
                    if (nxt) begin
                        if (m_pend) m_ovr = 1'b1;
                        else        m_pend = 1'b1;
                    end
                    if (rslt_vld) m_busy = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_nxt();
        @(posedge clk);
        #1 nxt = 1'b1;
        @(posedge clk);
        #1 nxt = 1'b0;
    endtask

    task automatic wait_conv(input int target);
        int k = 0;
        while (conv_cnt < target && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (conv_cnt < target) chk("conv_timeout", 32'(conv_cnt), 32'(target));
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((m_busy || m_pend) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (m_busy || m_pend) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_nwrt(input int n);
        int k = 0;
        while (nwrt < n && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (nwrt < n) chk("wrt_timeout", 32'(nwrt), 32'(n));
    endtask

    task automatic wait_ndone(input int n);
        int k = 0;
        while (ndone < n && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (ndone < n) chk("done_timeout", 32'(ndone), 32'(n));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        rst_n  = 1'b0;
        nxt    = 1'b0;
        adc[0] = 12'h200;
        adc[1] = 12'h300;
        adc[2] = 12'h800;
        adc[3] = 12'hC00;
        repeat (2) @(posedge clk);
        mon_en = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_lft",   32'(lft_ld),     32'h0);
        chk("rst_rght",  32'(rght_ld),    32'h0);
        chk("rst_steer", 32'(steer_pot),  32'h0);
        chk("rst_batt",  32'(batt),       32'h0);
        chk("rst_wrt",   32'(spi_if.wrt), 32'h0);
        chk("rst_cmd",   32'(spi_if.cmd), 32'h0);
        chk("rst_vld",   32'(rslt_vld),   32'h0);
        chk("rst_ovr",   32'(ovr),        32'h0);

        // one pass over all four channels
        for (int i = 0; i < 4; i++) begin
            wait_idle();
            base = conv_cnt;
            do_nxt();
            wait_conv(base + 1);
        end
        chk("pass_lft",   32'(lft_ld),    32'h200);
        chk("pass_rght",  32'(rght_ld),   32'h300);
        chk("pass_steer", 32'(steer_pot), 32'h800);
        chk("pass_batt",  32'(batt),      32'hC00);

        // pointer wraps back to the left load cell
        wait_idle();
        adc[0] = 12'h3FF;
        base = conv_cnt;
        do_nxt();
        wait_conv(base + 1);
        chk("wrap_lft", 32'(lft_ld), 32'h3FF);
        chk("wrap_rght", 32'(rght_ld), 32'h300);

        // one extra request during WT1 queues a single conversion
        wait_idle();
        base = conv_cnt;
        do_nxt();
        wait_nwrt(1);
        do_nxt();
        wait_conv(base + 2);
        repeat (60) @(negedge clk);
        chk("pend_convs", 32'(conv_cnt - base), 32'd2);
        chk("pend_no_ovr", 32'(ovr), 32'd0);

        // nxt coincident with CAP is queued, not lost
        wait_idle();
        base = conv_cnt;
        do_nxt();
        wait_ndone(2);
        do_nxt();
        wait_conv(base + 2);
        repeat (60) @(negedge clk);
        chk("cap_nxt_convs", 32'(conv_cnt - base), 32'd2);
        chk("cap_nxt_no_ovr", 32'(ovr), 32'd0);

        // two extra requests while busy: one runs, one is dropped
        wait_idle();
        base = conv_cnt;
        do_nxt();
        wait_nwrt(1);
        do_nxt();
        do_nxt();
        wait_conv(base + 2);
        repeat (60) @(negedge clk);
        chk("ovr_convs", 32'(conv_cnt - base), 32'd2);
        chk("ovr_set", 32'(ovr), 32'd1);

        // reset during WT2; the late done must be ignored
        wait_idle();
        do_nxt();
        wait_nwrt(2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("wt2rst_lft",   32'(lft_ld),    32'h0);
        chk("wt2rst_rght",  32'(rght_ld),   32'h0);
        chk("wt2rst_steer", 32'(steer_pot), 32'h0);
        chk("wt2rst_batt",  32'(batt),      32'h0);
        chk("wt2rst_ovr",   32'(ovr),       32'h0);
        base = conv_cnt;
        do_nxt();
        wait_conv(base + 1);
        chk("after_rst_lft", 32'(lft_ld), 32'h3FF);

        // stray done in IDLE
        wait_idle();
        base = conv_cnt;
        stray_req++;
        repeat (30) @(negedge clk);
        chk("stray_no_conv", 32'(conv_cnt), 32'(base));
        chk("stray_lft", 32'(lft_ld), 32'h3FF);

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            wait_idle();
            if ($urandom_range(0, 2) == 0) adc[$urandom_range(0, 3)] = 12'($urandom);
            do_nxt();
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 30)) @(posedge clk);
                do_nxt();
            end
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 30)) @(posedge clk);
                do_nxt();
            end
            repeat ($urandom_range(0, 10)) @(posedge clk);
        end
        wait_idle();
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
